// File: rtl/sme_pkg.sv
// Shared constants, state encoding and character comparison for the string-matching engine.
// Build option SME_CASE_FOLD_EN: literal comparison treats ASCII upper/lower case letters as equal.
package sme_pkg;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_STR,
        ST_LD_PAT,
        ST_SCAN,
        ST_DONE
    } sme_state_t;

    function automatic logic chars_eq8(input logic [7:0] a, input logic [7:0] b);
`ifdef SME_CASE_FOLD_EN
        logic [7:0] fa;
        logic [7:0] fb;
        fa = (a >= 8'h41 && a <= 8'h5A) ? (a | 8'h20) : a;
        fb = (b >= 8'h41 && b <= 8'h5A) ? (b | 8'h20) : b;
        return fa == fb;
`else
        return a == b;
`endif
    endfunction

endpackage

// File: rtl/sme_win_cmp.sv
// Combinational compare of the pattern window against the string at candidate position i_pos.
// Reports the literal hit and the state of both anchors; range checking is left to the caller.
module sme_win_cmp
    import sme_pkg::*;
#(
    parameter int CHAR_W      = 8,
    parameter int MAX_STR_LEN = 32,
    parameter int MAX_PAT_LEN = 8,
    parameter int IDX_W       = $clog2(MAX_STR_LEN),
    parameter int PLW         = $clog2(MAX_PAT_LEN + 1)
) (
    input  logic [MAX_STR_LEN-1:0][CHAR_W-1:0] i_str,
    input  logic [IDX_W:0]                     i_str_len,
    input  logic [MAX_PAT_LEN-1:0][CHAR_W-1:0] i_pat,
    input  logic [PLW-1:0]                     i_pat_len,
    input  logic [IDX_W:0]                     i_pos,
    output logic [PLW-1:0]                     o_lit_len,
    output logic                               o_lit_hit,
    output logic                               o_caret_ok,
    output logic                               o_dollar_ok
);

    // Special codes live in the low byte only, so folding applies only when upper bits are clear.
    function automatic logic ch_eq(input logic [CHAR_W-1:0] a, input logic [CHAR_W-1:0] b);
        return (a == b) || ((((a | b) >> 8) == '0) && chars_eq8(a[7:0], b[7:0]));
    endfunction

    logic             w_caret;
    logic             w_dollar;
    int               w_lit;
    logic [IDX_W-1:0] w_sidx;
    logic [IDX_W-1:0] w_cidx;
    logic [IDX_W-1:0] w_didx;

    always_comb begin
        w_caret  = (i_pat_len != '0) && (i_pat[0] == CHAR_W'(CH_CARET));
        w_dollar = 1'b0;
        for (int j = 0; j < MAX_PAT_LEN; j++) begin
            if ((int'(i_pat_len) == j + 1) && (i_pat[j] == CHAR_W'(CH_DOLLAR)))
                w_dollar = 1'b1;
        end
        w_lit     = int'(i_pat_len) - int'(w_caret) - int'(w_dollar);
        o_lit_len = PLW'(w_lit);

        o_lit_hit = 1'b1;
        w_sidx    = '0;
        for (int j = 0; j < MAX_PAT_LEN; j++) begin
            if ((j >= int'(w_caret)) && (j < int'(w_caret) + w_lit)) begin
                w_sidx = IDX_W'(int'(i_pos) + j - int'(w_caret));
                if ((i_pat[j] != CHAR_W'(CH_DOT)) && !ch_eq(i_str[w_sidx], i_pat[j]))
                    o_lit_hit = 1'b0;
            end
        end

        w_cidx      = IDX_W'(int'(i_pos) - 1);
        w_didx      = IDX_W'(int'(i_pos) + w_lit);
        o_caret_ok  = !w_caret || (i_pos == '0) || (i_str[w_cidx] == CHAR_W'(CH_SPACE));
        o_dollar_ok = !w_dollar || (int'(i_pos) + w_lit == int'(i_str_len))
                      || (i_str[w_didx] == CHAR_W'(CH_SPACE));
    end

endmodule

// File: rtl/sme_param.sv
// Single-pattern string matcher: buffers one string, then scans each loaded pattern one position per cycle.
// Literal comparison folds letter case when built with SME_CASE_FOLD_EN.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | after reset, no string loaded (length 0)
// ST_LD_STR | receiving string characters
// ST_LD_PAT | receiving pattern characters
// ST_SCAN   | evaluating candidate r_pos, one per cycle
// ST_DONE   | result presented, string held for further patterns
module sme_param
    import sme_pkg::*;
#(
    parameter int CHAR_W      = 8,
    parameter int MAX_STR_LEN = 32,
    parameter int MAX_PAT_LEN = 8,
    parameter int IDX_W       = $clog2(MAX_STR_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CHAR_W-1:0] chardata,
    input  logic              isstring,
    input  logic              ispattern,
    output logic              valid,
    output logic              match,
    output logic [IDX_W-1:0]  match_index
);

    localparam int SLW = IDX_W + 1;
    localparam int PLW = $clog2(MAX_PAT_LEN + 1);
    localparam int PIW = $clog2(MAX_PAT_LEN);
    localparam logic [SLW-1:0] STR_FULL = SLW'(MAX_STR_LEN);
    localparam logic [PLW-1:0] PAT_FULL = PLW'(MAX_PAT_LEN);

    sme_state_t                         r_state;
    logic [MAX_STR_LEN-1:0][CHAR_W-1:0] r_str;
    logic [MAX_PAT_LEN-1:0][CHAR_W-1:0] r_pat;
    logic [SLW-1:0]                     r_str_len;
    logic [PLW-1:0]                     r_pat_len;
    logic [SLW-1:0]                     r_pos;
    logic                               r_valid;
    logic                               r_match;
    logic [IDX_W-1:0]                   r_index;

    logic           w_lit_hit;
    logic           w_caret_ok;
    logic           w_dollar_ok;
    logic [PLW-1:0] w_lit_len;
    logic           w_no_cand;
    logic           w_last;
    logic           w_hit;

    sme_win_cmp #(
        .CHAR_W      (CHAR_W),
        .MAX_STR_LEN (MAX_STR_LEN),
        .MAX_PAT_LEN (MAX_PAT_LEN),
        .IDX_W       (IDX_W),
        .PLW         (PLW)
    ) u_win_cmp (
        .i_str       (r_str),
        .i_str_len   (r_str_len),
        .i_pat       (r_pat),
        .i_pat_len   (r_pat_len),
        .i_pos       (r_pos),
        .o_lit_len   (w_lit_len),
        .o_lit_hit   (w_lit_hit),
        .o_caret_ok  (w_caret_ok),
        .o_dollar_ok (w_dollar_ok)
    );

    // Candidates run from 0 to strlen-L; a pattern longer than the string still takes one scan cycle.
    always_comb begin
        w_no_cand = int'(w_lit_len) > int'(r_str_len);
        w_last    = w_no_cand || (int'(r_pos) + int'(w_lit_len) >= int'(r_str_len));
        w_hit     = !w_no_cand && w_lit_hit && w_caret_ok && w_dollar_ok;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_str     <= '0;
            r_pat     <= '0;
            r_str_len <= '0;
            r_pat_len <= '0;
            r_pos     <= '0;
            r_valid   <= 1'b0;
            r_match   <= 1'b0;
            r_index   <= '0;
        end else begin
            r_valid <= 1'b0;
            if (isstring) begin
                if (r_state != ST_LD_STR) begin
                    r_str[0]  <= chardata;
                    r_str_len <= SLW'(1);
                end else if (r_str_len < STR_FULL) begin
                    r_str[r_str_len[IDX_W-1:0]] <= chardata;
                    r_str_len <= r_str_len + SLW'(1);
                end
                r_state <= ST_LD_STR;
            end else if (ispattern) begin
                if (r_state != ST_LD_PAT) begin
                    r_pat[0]  <= chardata;
                    r_pat_len <= PLW'(1);
                end else if (r_pat_len < PAT_FULL) begin
                    r_pat[r_pat_len[PIW-1:0]] <= chardata;
                    r_pat_len <= r_pat_len + PLW'(1);
                end
                r_state <= ST_LD_PAT;
            end else begin
                case (r_state)
                    ST_LD_STR: r_state <= ST_DONE;
                    ST_LD_PAT: begin
                        r_state <= ST_SCAN;
                        r_pos   <= '0;
                    end
                    ST_SCAN: begin
                        if (w_hit) begin
                            r_valid <= 1'b1;
                            r_match <= 1'b1;
                            r_index <= r_pos[IDX_W-1:0];
                            r_state <= ST_DONE;
                        end else if (w_last) begin
                            r_valid <= 1'b1;
                            r_match <= 1'b0;
                            r_index <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_pos <= r_pos + SLW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign valid       = r_valid;
    assign match       = r_match;
    assign match_index = r_index;

endmodule
